// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop sequence.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic [DATA_WIDTH-1:0] par_data,
  output logic                  par_load,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_TWO_STOP_EN
    STOP,
    STOP2
`else
    STOP
`endif
  } state_e;

`ifdef UART_TX_TWO_STOP_EN
  localparam state_e FINAL = STOP2;
`else
  localparam state_e FINAL = STOP;
`endif

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pen_q, pen_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  load_q, load_d;
  logic                  can_acc;

  assign can_acc = (state_q == IDLE) || (state_q == FINAL);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pdata_d = pdata_q;
    cnt_d   = cnt_q;
    pen_d   = pen_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START: begin
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (pen_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP: begin
        state_d = STOP2;
        tx_d    = 1'b1;
      end
      STOP2: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
`else
      STOP: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    // acceptance overrides the end-of-frame move for back-to-back frames
    if (can_acc && DATA_Valid) begin
      state_d = START;
      shift_d = P_DATA;
      pdata_d = P_DATA;
      pen_d   = PAR_EN;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      load_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      pdata_q <= '0;
      cnt_q   <= '0;
      pen_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pdata_q <= pdata_d;
      cnt_q   <= cnt_d;
      pen_q   <= pen_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
    end
  end

  assign par_data = pdata_q;
  assign par_load = load_q;
  assign TX_OUT   = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed and random frames vs a bit-stream model.
// Honours UART_TX_TWO_STOP_EN for frame length.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       DATA_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       par_bit = 1'b0;
  logic [7:0] par_data;
  logic       par_load;
  logic       TX_OUT;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_Valid (DATA_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .par_data   (par_data),
    .par_load   (par_load),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // even-mode parity calculator, one cycle latency
  always @(posedge CLK)
    if (par_load) par_bit <= ^par_data;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] d,
                                   input bit pen,
                                   input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (pen && j == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic frame(input logic [7:0] d, input bit pen,
                       input int gap, input bit junk,
                       input logic [7:0] jd);
    int len;
    len = 10 + (pen ? 1 : 0) + (NSTOP - 1);
    P_DATA     = d;
    PAR_EN     = pen;
    DATA_Valid = 1'b1;
    for (int j = 0; j < len; j++) begin
      tick();
      check("tx", 32'(TX_OUT), 32'(exp_bit(d, pen, j)));
      check("busy", 32'(busy), 32'd1);
      check("load", 32'(par_load), 32'(j == 0));
      check("pdata", 32'(par_data), 32'(d));
      if (j < len - 1) begin
        DATA_Valid = junk;
        P_DATA     = jd;
        PAR_EN     = ~pen;
      end else begin
        DATA_Valid = 1'b0;
      end
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      check("idle_tx", 32'(TX_OUT), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_load", 32'(par_load), 32'd0);
    end
  endtask

  initial begin
    #2 RST = 1'b0;
    DATA_Valid = 1'b1;
    P_DATA     = 8'hA5;
    #1;
    check("rst_tx0", 32'(TX_OUT), 32'd1);
    check("rst_pdata", 32'(par_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_tx", 32'(TX_OUT), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_load", 32'(par_load), 32'd0);
    end
    DATA_Valid = 1'b0;
    RST = 1'b1;
    tick();
    check("post_rst_tx", 32'(TX_OUT), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    frame(8'hA5, 1'b0, 2, 1'b0, 8'h00);
    frame(8'h01, 1'b1, 1, 1'b0, 8'h00);
    frame(8'h00, 1'b0, 0, 1'b0, 8'h00);
    frame(8'hFF, 1'b0, 1, 1'b0, 8'h00);
    frame(8'h5A, 1'b0, 0, 1'b1, 8'h3C);
    frame(8'h3C, 1'b0, 2, 1'b0, 8'h00);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d, jd;
      bit pen, junk;
      int gap;
      d    = 8'($urandom);
      jd   = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      junk = 1'($urandom_range(0, 1));
      gap  = (k == 39) ? 1 : int'($urandom_range(0, 2));
      frame(d, pen, gap, junk, jd);
    end

    P_DATA     = 8'hC3;
    PAR_EN     = 1'b0;
    DATA_Valid = 1'b1;
    tick();
    DATA_Valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_bit3", 32'(TX_OUT), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    RST = 1'b0;
    #1;
    check("arst_tx", 32'(TX_OUT), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pdata", 32'(par_data), 32'd0);
    #2 RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rel_tx", 32'(TX_OUT), 32'd1);
      check("rel_busy", 32'(busy), 32'd0);
      check("rel_load", 32'(par_load), 32'd0);
    end
    frame(8'hA5, 1'b0, 1, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit sequencer. It accepts a parallel byte on a valid handshake and drives one serial frame on TX_OUT: start bit, DATA_WIDTH data bits LSB first, an optional parity bit, then stop bit(s).
It owns the frame FSM, the bit counter and the data shift register. Parity comes from the team's parity calculator: this block loads that calculator via par_load/par_data and consumes its par_bit.
One bit is sent per CLK cycle, because CLK is the baud clock.

Parameters:
DATA_WIDTH, 8, payload bits per frame; also the width of P_DATA and par_data.

Ports:
CLK  input  1  baud-rate clock, rising edge.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  byte to transmit.
DATA_Valid  input  1  P_DATA valid; accepted per the handshake rules.
PAR_EN  input  1  parity enable; sampled only at acceptance.
par_bit  input  1  parity result from the parity calculator.
par_data  output  DATA_WIDTH  latched byte driven to the parity calculator's data input.
par_load  output  1  one-cycle strobe to the parity calculator's valid input.
TX_OUT  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST=0, asynchronous), regardless of what is in flight:
  - state=IDLE, TX_OUT=1, busy=0, par_load=0, par_data=0, shift register=0, bit counter=0.
  - A reset mid-frame abandons the frame; the line returns high immediately.
- All outputs are registered; nothing combinational goes to a port.
- States: IDLE, START, DATA, PARITY, STOP (plus STOP2 with the optional feature).
- Acceptance:
  - A frame is accepted at rising edge E0 when DATA_Valid=1 and the FSM is in IDLE or in the final stop cycle.
  - At E0: P_DATA is latched into the shift register and into par_data, and PAR_EN is latched into par_en_q.
  - DATA_Valid=1 in any other state is ignored (no latch, no error). Upstream holds data until busy=0 or the final stop cycle.
- Frame timing after acceptance at E0:
  - After E0: state=START, TX_OUT=0, busy=1, par_load=1 for exactly one cycle.
  - After E1..E(DATA_WIDTH): state=DATA; TX_OUT=shift[0], with a shift right each cycle (LSB first). The bit counter runs 0..DATA_WIDTH-1, then wraps to 0.
  - After E(DATA_WIDTH+1): if par_en_q=1, state=PARITY and TX_OUT=par_bit. Otherwise go straight to STOP.
  - STOP: TX_OUT=1 for one cycle.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- End of frame, on the edge that leaves the final stop cycle:
  - DATA_Valid=0: go to IDLE, busy=0, TX_OUT=1.
  - DATA_Valid=1: accept back-to-back; the next state is START with no idle gap, and busy stays 1.
- Parity calculator latency: par_bit is valid one cycle after par_load and is sampled DATA_WIDTH cycles later, so its settling time is guaranteed.
- PAR_EN changes mid-frame have no effect on the current frame.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP is followed by STOP2. TX_OUT=1 for two cycles, and the frame is one cycle longer.
  - Back-to-back acceptance happens only in STOP2.
  - DATA_Valid during STOP is ignored.
- Undefined: a single stop bit. STOP2 and its logic are not compiled.

Test Plan:
- Reset: hold RST=0 with DATA_Valid=1 and P_DATA=8'hA5 -> TX_OUT=1, busy=0, par_load=0 throughout; no frame starts until RST=1.
- No parity: PAR_EN=0, P_DATA=8'hA5, DATA_Valid pulsed one cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles); busy high for 10 cycles, then 0.
- Parity: PAR_EN=1, P_DATA=8'h01, par_bit from the calculator in even mode -> TX_OUT sequence 0,1,0,0,0,0,0,0,0,1,1 (parity bit=1, 11 cycles).
  - Also check par_load pulses exactly once and par_data=8'h01.
- Back-to-back: hold DATA_Valid=1 with P_DATA=8'h00, then 8'hFF -> the second start bit immediately follows the first stop bit; busy never drops.
- Ignore while busy: change P_DATA to 8'h3C with DATA_Valid=1 mid-DATA -> the current frame is unchanged, and 8'h3C is accepted only in the stop cycle.
- Mid-frame reset: assert RST=0 during data bit 3 -> TX_OUT=1 and busy=0 asynchronously; after release, the FSM sits in IDLE.
  - With UART_TX_TWO_STOP_EN defined, repeat the no-parity case and expect two trailing 1s (11 cycles).
